// File: rtl/spi_master_shifter_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_shifter_pkg
//
// Shared definitions for the SPI master serial engine:
//   - default bus width, SCLK half-period divider and state register width
//   - state encodings of the shifter FSM
//
// No ports; imported by spi_master_shifter and spi_clock_divider.
// ---------------------------------------------------------------------------
package spi_master_shifter_pkg;

   // Default parameter values for the shifter and its divider.
   localparam int DATAWIDTH_BUS_DEF = 8;
   localparam int CLK_DIV_DEF       = 4;
   localparam int STATE_SIZE_DEF    = 3;

   // FSM encodings. Anything not listed is treated as illegal and recovers
   // to IDLE.
   typedef enum logic [STATE_SIZE_DEF-1:0] {
      ST_IDLE  = 3'b000,
      ST_SETUP = 3'b001,
      ST_HIGH  = 3'b010,
      ST_LOW   = 3'b011,
      ST_DONE  = 3'b100
   } state_e;

endpackage : spi_master_shifter_pkg

// File: rtl/spi_clock_divider.sv
// ---------------------------------------------------------------------------
// spi_clock_divider
//
// Half-period counter for the SPI shifter. Counts system-clock cycles from
// 0 to CLK_DIV-1 and raises a terminal-count pulse in the cycle where the
// count sits at CLK_DIV-1. The count restarts from 0 after every terminal
// count, so the pulse recurs every CLK_DIV cycles while clear is low.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clear  in   hold the count at 0 (no terminal count while asserted)
//   tc     out  terminal-count pulse (combinational from the count register)
// ---------------------------------------------------------------------------
module spi_clock_divider
   import spi_master_shifter_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tc
);

   // Keep the counter at least one bit wide so CLK_DIV=1 still elaborates;
   // with CLK_DIV=1 the count never leaves 0 and tc is high every cycle.
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tc = !clear && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tc) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule : spi_clock_divider

// File: rtl/spi_master_shifter.sv
// ---------------------------------------------------------------------------
// spi_master_shifter
//
// Serial engine of the SPI master. On a one-cycle start strobe in IDLE it
// latches a parallel word and shifts it out MSB-first in SPI mode 0
// (CPOL=0, CPHA=0) while sampling MISO into a receive word on every SCLK
// rising edge. When the word is complete it presents the received data with
// a one-cycle valid strobe and drops busy.
//
// Every output is a register: the next-state and next-output logic is
// combinational, and a single sequential block captures state, datapath and
// outputs together, so outputs change on the same edge as the state.
//
// Ports:
//   SPI_MASTER_SHIFTER_CLOCK_50        in   system clock, rising edge
//   SPI_MASTER_SHIFTER_RESET_InLow     in   asynchronous active-low reset
//   SPI_MASTER_SHIFTER_start_InHigh    in   start strobe (ignored unless IDLE)
//   SPI_MASTER_SHIFTER_data_In         in   word to transmit
//   SPI_MASTER_SHIFTER_MISO_In         in   serial data from the slave
//   SPI_MASTER_SHIFTER_SCLK_Out        out  serial clock, idles low
//   SPI_MASTER_SHIFTER_MOSI_Out        out  serial data to the slave
//   SPI_MASTER_SHIFTER_SS_OutLow       out  slave select, active low
//   SPI_MASTER_SHIFTER_masterBusy_Out  out  transaction in progress
//   SPI_MASTER_SHIFTER_rxData_Out      out  last received word
//   SPI_MASTER_SHIFTER_rxValid_Out     out  one-cycle strobe when rxData updates
//   SPI_MASTER_SHIFTER_state_Out       out  current FSM state (debug)
//
// Handshake: start is a single-cycle request that is accepted only on an
// edge where the FSM is IDLE; data_In is sampled on that edge only. A start
// seen while busy is dropped, not queued. rxValid is a single-cycle
// qualifier for rxData with no back-pressure.
// ---------------------------------------------------------------------------
module spi_master_shifter
   import spi_master_shifter_pkg::*;
#(
   parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
   parameter int CLK_DIV       = CLK_DIV_DEF,
   parameter int STATE_SIZE    = STATE_SIZE_DEF
) (
   input  logic                     SPI_MASTER_SHIFTER_CLOCK_50,
   input  logic                     SPI_MASTER_SHIFTER_RESET_InLow,
   input  logic                     SPI_MASTER_SHIFTER_start_InHigh,
   input  logic [DATAWIDTH_BUS-1:0] SPI_MASTER_SHIFTER_data_In,
   input  logic                     SPI_MASTER_SHIFTER_MISO_In,
   output logic                     SPI_MASTER_SHIFTER_SCLK_Out,
   output logic                     SPI_MASTER_SHIFTER_MOSI_Out,
   output logic                     SPI_MASTER_SHIFTER_SS_OutLow,
   output logic                     SPI_MASTER_SHIFTER_masterBusy_Out,
   output logic [DATAWIDTH_BUS-1:0] SPI_MASTER_SHIFTER_rxData_Out,
   output logic                     SPI_MASTER_SHIFTER_rxValid_Out,
   output logic [STATE_SIZE-1:0]    SPI_MASTER_SHIFTER_state_Out
);

   localparam int W     = DATAWIDTH_BUS;
   localparam int BIT_W = $clog2(DATAWIDTH_BUS);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATAWIDTH_BUS - 1);

   localparam logic [STATE_SIZE-1:0] S_IDLE  = STATE_SIZE'(ST_IDLE);
   localparam logic [STATE_SIZE-1:0] S_SETUP = STATE_SIZE'(ST_SETUP);
   localparam logic [STATE_SIZE-1:0] S_HIGH  = STATE_SIZE'(ST_HIGH);
   localparam logic [STATE_SIZE-1:0] S_LOW   = STATE_SIZE'(ST_LOW);
   localparam logic [STATE_SIZE-1:0] S_DONE  = STATE_SIZE'(ST_DONE);

   // Short local names for the ports.
   logic clk;
   logic rst_n;
   logic start;
   logic miso;
   assign clk   = SPI_MASTER_SHIFTER_CLOCK_50;
   assign rst_n = SPI_MASTER_SHIFTER_RESET_InLow;
   assign start = SPI_MASTER_SHIFTER_start_InHigh;
   assign miso  = SPI_MASTER_SHIFTER_MISO_In;

   // Current state and datapath registers.
   logic [STATE_SIZE-1:0] state;
   logic [W-1:0]          tx;
   logic [W-1:0]          rx;
   logic [BIT_W-1:0]      bit_cnt;

   // Registered outputs.
   logic                  sclk;
   logic                  mosi;
   logic                  ss_n;
   logic                  busy;
   logic [W-1:0]          rx_data;
   logic                  rx_valid;

   // Next values.
   logic [STATE_SIZE-1:0] state_d;
   logic [W-1:0]          tx_d;
   logic [W-1:0]          rx_d;
   logic [BIT_W-1:0]      bit_d;
   logic                  sclk_d;
   logic                  mosi_d;
   logic                  ss_n_d;
   logic                  busy_d;
   logic [W-1:0]          rx_data_d;
   logic                  rx_valid_d;

   logic                  active;
   logic                  active_d;
   logic                  tc;

   // A transaction occupies SETUP..DONE; IDLE and illegal encodings are not
   // active.
   assign active = (state == S_SETUP) || (state == S_HIGH) ||
                   (state == S_LOW)   || (state == S_DONE);

   // The divider is held clear whenever no transaction is running, so the
   // first half-period after the accepting edge is exactly CLK_DIV cycles.
   spi_clock_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (!active),
      .tc    (tc)
   );

   // ------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------
   always_comb begin : next_state_logic
      state_d = state;
      tx_d    = tx;
      rx_d    = rx;
      bit_d   = bit_cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETUP;
               tx_d    = SPI_MASTER_SHIFTER_data_In;
               rx_d    = '0;
               bit_d   = '0;
            end
         end
         S_SETUP: begin
            // Entering HIGH is an SCLK rise: capture MISO on that edge.
            if (tc) begin
               state_d = S_HIGH;
               rx_d    = {rx[W-2:0], miso};
            end
         end
         S_HIGH: begin
            if (tc) begin
               if (bit_cnt == LAST_BIT) begin
                  // Last bit: keep MOSI stable through the hold period.
                  state_d = S_DONE;
               end else begin
                  // SCLK fall: present the next bit on MOSI.
                  state_d = S_LOW;
                  tx_d    = {tx[W-2:0], 1'b0};
                  bit_d   = bit_cnt + BIT_W'(1);
               end
            end
         end
         S_LOW: begin
            if (tc) begin
               state_d = S_HIGH;
               rx_d    = {rx[W-2:0], miso};
            end
         end
         S_DONE: begin
            if (tc) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Next-output logic. Outputs are derived from the state being entered
   // so that the registered outputs line up with the registered state.
   // ------------------------------------------------------------------
   always_comb begin : next_output_logic
      active_d   = (state_d == S_SETUP) || (state_d == S_HIGH) ||
                   (state_d == S_LOW)   || (state_d == S_DONE);
      sclk_d     = (state_d == S_HIGH);
      ss_n_d     = !active_d;
      busy_d     = active_d;
      mosi_d     = active_d && tx_d[W-1];
      rx_valid_d = (state == S_DONE) && tc;
      rx_data_d  = rx_valid_d ? rx : rx_data;
   end

   // ------------------------------------------------------------------
   // Register block. Reset clears rxData too, so an aborted transaction
   // never leaves a partial word behind.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin : regs
      if (!rst_n) begin
         state    <= S_IDLE;
         tx       <= '0;
         rx       <= '0;
         bit_cnt  <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         ss_n     <= 1'b1;
         busy     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         state    <= state_d;
         tx       <= tx_d;
         rx       <= rx_d;
         bit_cnt  <= bit_d;
         sclk     <= sclk_d;
         mosi     <= mosi_d;
         ss_n     <= ss_n_d;
         busy     <= busy_d;
         rx_data  <= rx_data_d;
         rx_valid <= rx_valid_d;
      end
   end

   assign SPI_MASTER_SHIFTER_SCLK_Out       = sclk;
   assign SPI_MASTER_SHIFTER_MOSI_Out       = mosi;
   assign SPI_MASTER_SHIFTER_SS_OutLow      = ss_n;
   assign SPI_MASTER_SHIFTER_masterBusy_Out = busy;
   assign SPI_MASTER_SHIFTER_rxData_Out     = rx_data;
   assign SPI_MASTER_SHIFTER_rxValid_Out    = rx_valid;
   assign SPI_MASTER_SHIFTER_state_Out      = state;

endmodule : spi_master_shifter

// File: tb/tb_spi_master_shifter.sv
// ---------------------------------------------------------------------------
// tb_spi_master_shifter
//
// Bench for spi_master_shifter. One instance with default parameters runs a
// table of loopback / slave-model transactions plus hand-written sequences
// (ignored restart, mid-transaction reset); a second instance with
// CLK_DIV=1 runs back-to-back transactions with start held high.
// ---------------------------------------------------------------------------
module tb_spi_master_shifter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- default-parameter DUT ----------------
   logic       start;
   logic [7:0] data;
   logic       miso;
   logic       sclk, mosi, ss, busy, rx_valid;
   logic [7:0] rx_data;
   logic [2:0] state_dbg;

   spi_master_shifter dut (
      .SPI_MASTER_SHIFTER_CLOCK_50       (clk),
      .SPI_MASTER_SHIFTER_RESET_InLow    (rst_n),
      .SPI_MASTER_SHIFTER_start_InHigh   (start),
      .SPI_MASTER_SHIFTER_data_In        (data),
      .SPI_MASTER_SHIFTER_MISO_In        (miso),
      .SPI_MASTER_SHIFTER_SCLK_Out       (sclk),
      .SPI_MASTER_SHIFTER_MOSI_Out       (mosi),
      .SPI_MASTER_SHIFTER_SS_OutLow      (ss),
      .SPI_MASTER_SHIFTER_masterBusy_Out (busy),
      .SPI_MASTER_SHIFTER_rxData_Out     (rx_data),
      .SPI_MASTER_SHIFTER_rxValid_Out    (rx_valid),
      .SPI_MASTER_SHIFTER_state_Out      (state_dbg)
   );

   // ---------------- CLK_DIV=1 DUT (loopback) ----------------
   logic       start1;
   logic [7:0] data1;
   logic       sclk1, mosi1, ss1, busy1, rx_valid1;
   logic [7:0] rx_data1;
   logic [2:0] state_dbg1;

   spi_master_shifter #(.CLK_DIV(1)) dut1 (
      .SPI_MASTER_SHIFTER_CLOCK_50       (clk),
      .SPI_MASTER_SHIFTER_RESET_InLow    (rst_n),
      .SPI_MASTER_SHIFTER_start_InHigh   (start1),
      .SPI_MASTER_SHIFTER_data_In        (data1),
      .SPI_MASTER_SHIFTER_MISO_In        (mosi1),
      .SPI_MASTER_SHIFTER_SCLK_Out       (sclk1),
      .SPI_MASTER_SHIFTER_MOSI_Out       (mosi1),
      .SPI_MASTER_SHIFTER_SS_OutLow      (ss1),
      .SPI_MASTER_SHIFTER_masterBusy_Out (busy1),
      .SPI_MASTER_SHIFTER_rxData_Out     (rx_data1),
      .SPI_MASTER_SHIFTER_rxValid_Out    (rx_valid1),
      .SPI_MASTER_SHIFTER_state_Out      (state_dbg1)
   );

   // ---------------- mode-0 slave model ----------------
   // Loads its transmit byte while deselected, samples MOSI on SCLK rise,
   // shifts its own byte on SCLK fall. Evaluated on the falling system clock.
   logic       loop_mode;
   logic [7:0] slv_seed;
   logic [7:0] slv_sh = 8'h00;
   logic [7:0] slv_rx = 8'h00;
   logic       slv_sclk_p = 1'b0;

   always @(negedge clk) begin
      if (ss) begin
         slv_sh = slv_seed;
      end else begin
         if (sclk && !slv_sclk_p) slv_rx = {slv_rx[6:0], mosi};
         if (!sclk && slv_sclk_p) slv_sh = {slv_sh[6:0], 1'b0};
      end
      slv_sclk_p = sclk;
   end

   assign miso = loop_mode ? mosi : slv_sh[7];

   // ---------------- scoreboard counters ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Drive start for one edge (edge 0 of the transaction), then scramble
   // data_In so only the accepting edge can have captured it.
   task automatic launch(input logic [7:0] d);
      @(posedge clk); #1;
      start = 1'b1;
      data  = d;
      @(posedge clk); #1;
      start = 1'b0;
      data  = ~d;
   endtask

   // Observe n edges after edge 0. Optionally pulse start again at
   // pulse_edge (relative to edge 0) with pulse_data.
   task automatic watch(input int n, input int pulse_edge, input logic [7:0] pulse_data,
                        output int v_edge, output int v_cnt, output int b_cnt,
                        output int b_last, output int rises, output logic [7:0] seq,
                        output logic [7:0] rx_at_v);
      logic sclk_p;
      sclk_p  = sclk;
      v_edge  = -1;
      v_cnt   = 0;
      b_cnt   = busy ? 1 : 0;
      b_last  = busy ? 0 : -1;
      rises   = 0;
      seq     = 8'h00;
      rx_at_v = 8'h00;
      for (int e = 1; e <= n; e++) begin
         @(posedge clk); #1;
         if (busy) begin
            b_cnt++;
            b_last = e;
         end
         if (rx_valid) begin
            v_cnt++;
            if (v_edge < 0) begin
               v_edge  = e;
               rx_at_v = rx_data;
            end
         end
         if (sclk && !sclk_p && !ss) begin
            rises++;
            seq = {seq[6:0], mosi};
         end
         sclk_p = sclk;
         start  = (e + 1 == pulse_edge);
         if (start) data = pulse_data;
      end
      start = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] tx;
      logic       loop;
      logic [7:0] slv;
      logic [7:0] exp_rx;
      logic [7:0] exp_slv;
   } vec_t;

   vec_t vecs[5];

   int         v_edge, v_cnt, b_cnt, b_last, rises;
   logic [7:0] seq, rx_at_v;

   // Full set of checks for one default-parameter transaction.
   task automatic check_txn(input string tag, input logic [7:0] tx, input logic [7:0] exp_rx);
      chk({tag, "_valid_edge"}, v_edge, 68);
      chk({tag, "_valid_count"}, v_cnt, 1);
      chk({tag, "_busy_cycles"}, b_cnt, 68);
      chk({tag, "_busy_last_edge"}, b_last, 67);
      chk({tag, "_sclk_rises"}, rises, 8);
      chk({tag, "_mosi_bits"}, seq, tx);
      chk({tag, "_rx_at_valid"}, rx_at_v, exp_rx);
      chk({tag, "_rx_hold"}, rx_data, exp_rx);
   endtask

   // ---------------- main test ----------------
   initial begin
      int nv, nb, vc, sbad, r;
      int         ve[3];
      logic [7:0] vr[3];
      logic [3:0] ss_samp;

      vecs[0] = '{tx: 8'hA5, loop: 1'b1, slv: 8'h00, exp_rx: 8'hA5, exp_slv: 8'h00};
      vecs[1] = '{tx: 8'hC3, loop: 1'b0, slv: 8'h3C, exp_rx: 8'h3C, exp_slv: 8'hC3};
      vecs[2] = '{tx: 8'h00, loop: 1'b1, slv: 8'h00, exp_rx: 8'h00, exp_slv: 8'h00};
      vecs[3] = '{tx: 8'hFF, loop: 1'b0, slv: 8'h00, exp_rx: 8'h00, exp_slv: 8'hFF};
      vecs[4] = '{tx: 8'h81, loop: 1'b0, slv: 8'h7E, exp_rx: 8'h7E, exp_slv: 8'h81};

      rst_n     = 1'b0;
      start     = 1'b0;
      data      = 8'h00;
      start1    = 1'b0;
      data1     = 8'h00;
      loop_mode = 1'b1;
      slv_seed  = 8'h00;

      // Reset values
      #12;
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_ss", ss, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_state", state_dbg, 0);
      chk("rst_ss_div1", ss1, 1);
      chk("rst_state_div1", state_dbg1, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven transactions
      for (int i = 0; i < 5; i++) begin
         loop_mode = vecs[i].loop;
         slv_seed  = vecs[i].slv;
         launch(vecs[i].tx);
         chk($sformatf("v%0d_e0_busy", i), busy, 1);
         chk($sformatf("v%0d_e0_ss", i), ss, 0);
         chk($sformatf("v%0d_e0_mosi", i), mosi, vecs[i].tx[7]);
         watch(80, -1, 8'h00, v_edge, v_cnt, b_cnt, b_last, rises, seq, rx_at_v);
         check_txn($sformatf("v%0d", i), vecs[i].tx, vecs[i].exp_rx);
         if (!vecs[i].loop) chk($sformatf("v%0d_slave_rx", i), slv_rx, vecs[i].exp_slv);
      end

      // Start at edge 20 while busy is dropped
      loop_mode = 1'b1;
      launch(8'h11);
      watch(100, 20, 8'h22, v_edge, v_cnt, b_cnt, b_last, rises, seq, rx_at_v);
      check_txn("restart_ignored", 8'h11, 8'h11);

      // CLK_DIV=1, start held high, 0xFF / 0x00 alternating
      @(posedge clk); #1;
      start1 = 1'b1;
      data1  = 8'hFF;
      @(posedge clk); #1;
      chk("div1_e0_busy", busy1, 1);
      chk("div1_e0_mosi", mosi1, 1);
      vc      = 0;
      sbad    = 0;
      ss_samp = 4'h0;
      for (int e = 1; e <= 54; e++) begin
         @(posedge clk); #1;
         r = e % 18;
         if (r >= 1 && r <= 16 && e <= 52) begin
            if (sclk1 !== r[0]) sbad++;
         end
         if (rx_valid1) begin
            if (vc < 3) begin
               ve[vc] = e;
               vr[vc] = rx_data1;
            end
            vc++;
            data1 = (vc % 2 == 1) ? 8'h00 : 8'hFF;
         end
         if (e == 17) ss_samp[0] = ss1;
         if (e == 18) ss_samp[1] = ss1;
         if (e == 35) ss_samp[2] = ss1;
         if (e == 36) ss_samp[3] = ss1;
         if (e == 53) start1 = 1'b0;
      end
      chk("div1_valid_count", vc, 3);
      if (vc >= 3) begin
         chk("div1_done0_edge", ve[0], 17);
         chk("div1_done1_edge", ve[1], 35);
         chk("div1_done2_edge", ve[2], 53);
         chk("div1_rx0", vr[0], 8'hFF);
         chk("div1_rx1", vr[1], 8'h00);
         chk("div1_rx2", vr[2], 8'hFF);
      end
      chk("div1_sclk_toggle_errs", sbad, 0);
      chk("div1_ss_gap", ss_samp, 4'b0101);

      // Reset at edge 30 of a transaction, then restart at edge 40
      loop_mode = 1'b1;
      launch(8'h5A);
      repeat (29) @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_sclk", sclk, 0);
      chk("midrst_mosi", mosi, 0);
      chk("midrst_ss", ss, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_rx_data", rx_data, 0);
      chk("midrst_rx_valid", rx_valid, 0);
      chk("midrst_state", state_dbg, 0);
      nv = 0;
      nb = 0;
      for (int e = 31; e <= 39; e++) begin
         @(posedge clk); #1;
         if (e == 32) rst_n = 1'b1;
         if (rx_valid) nv++;
         if (busy) nb++;
         if (e == 39) begin
            start = 1'b1;
            data  = 8'h5A;
         end
      end
      chk("midrst_no_valid", nv, 0);
      chk("midrst_no_busy", nb, 0);
      @(posedge clk); #1;
      start = 1'b0;
      data  = 8'h00;
      chk("after_rst_e0_busy", busy, 1);
      chk("after_rst_e0_mosi", mosi, 0);
      watch(80, -1, 8'h00, v_edge, v_cnt, b_cnt, b_last, rises, seq, rx_at_v);
      check_txn("after_rst", 8'h5A, 8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_spi_master_shifter
